acc_multicanal: RTL and testbench
=================================

Name: acc_multicanal

Overview:
- Parametrised successor of the single 16-bit accumulator: NUM_CH independent signed accumulators of WIDTH bits.
- Supports ADD/SUB/LOAD operations, per-channel and global clear, and sticky per-channel overflow flags.
- Has a registered read port with write-through.
- Sits between the datapath ALU output and the register/display logic; one operation per clock.

Parameters:
- WIDTH, 16, data and accumulator width in bits (two's complement).
- NUM_CH, 4, number of accumulator channels (>=1).
- CH_W, 2, channel-select width; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous reset, active-low.
- Entrada  input  WIDTH  operand.
- Canal  input  CH_W  channel targeted by WrAcc/Clear.
- Op  input  2  operation: 00 ADD, 01 SUB, 10 LOAD, 11 NOP.
- WrAcc  input  1  operation strobe; Op is applied to Canal when 1.
- Clear  input  1  zero channel Canal.
- ClearAll  input  1  zero all channels.
- RdCanal  input  CH_W  channel to read.
- Salida  output  WIDTH  registered value of channel RdCanal.
- Overflow  output  NUM_CH  sticky overflow flag per channel.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low (rst_n sampled on posedge clk).
- rst_n=0 at an edge: all accumulators, Salida and Overflow become 0. All other inputs are ignored that edge, including when rst_n falls mid-stream.
- Per-edge evaluation order for the targeted channel:
  1. Clear or ClearAll: base = 0 and the channel's flag is cleared. Otherwise base = current value and the flag is retained.
  2. If WrAcc=1 and Op!=NOP: result = f(base, Entrada). Otherwise result = base.
- Simultaneous Clear (or ClearAll) and WrAcc on the same channel therefore yields Op applied to 0.
- ClearAll zeroes every channel and flag, then the WrAcc op is applied to Canal as above.
- ADD: base + Entrada, WIDTH-bit. Overflow when operand signs are equal and the result sign differs.
- SUB: base - Entrada, WIDTH-bit. Overflow when operand signs differ and the result sign differs from base.
- LOAD: result = Entrada; never overflows. The flag is kept (not cleared) unless Clear is also asserted.
- On overflow: Overflow[Canal] is set to 1 and stays set until Clear of that channel, ClearAll, or reset.
- Channel range: Canal >= NUM_CH makes WrAcc and Clear no-ops (ClearAll still acts).
- Read port: Salida updates at every edge with 1-cycle latency.
  - RdCanal >= NUM_CH reads 0.
  - Write-through: if RdCanal's channel is updated at the same edge (by Canal match or ClearAll), Salida takes the new value, not the old.
- Outputs come only from flops; there is no combinational path from inputs to Salida or Overflow.
- Untargeted channels hold their value.

Optional Feature:
- Macro: ACC_MULTICANAL_SAT_EN.
- Defined: ADD/SUB results that overflow saturate to +2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow). The Overflow flag is still set.
- Undefined: results wrap modulo 2^WIDTH and the Overflow flag is set.
- LOAD, Clear and the read path are identical in both builds.

Test Plan:
All cases use WIDTH=16, NUM_CH=4.
1. Reset: rst_n=0 for one edge with WrAcc=1, Op=ADD, Entrada=0x1234 -> after the edge Salida=0x0000, Overflow=4'b0000, and all channels read 0x0000.
2. Accumulate: Canal=1, RdCanal=1, Op=ADD, Entrada=0x0005, WrAcc=1 for 3 edges -> Salida=0x0005, 0x000A, 0x000F after successive edges (write-through); channels 0, 2 and 3 read 0x0000.
3. Positive overflow: LOAD ch2=0x7FFF, then ADD 0x0001 -> Overflow[2]=1. Wrap build reads 0x8000; SAT build reads 0x7FFF. A further LOAD 0x0010 leaves Overflow[2]=1.
4. Clear/write collision: ch1=0x000F, same edge Clear=1, WrAcc=1, Op=ADD, Entrada=0x0003 -> ch1=0x0003, Overflow[1]=0.
5. Negative-edge SUB: ch3=0x0000, SUB Entrada=0x8000 -> Overflow[3]=1. Wrap build reads 0x8000; SAT build reads 0x7FFF. Next, ClearAll with WrAcc ADD 0x0002 on ch0 -> ch0=0x0002, ch1..3=0x0000, Overflow=4'b0000.
6. Out-of-range channel: NUM_CH=3 build, Canal=3, WrAcc ADD 0x0001 with Clear=1 -> no channel changes, no flag changes; RdCanal=3 reads 0x0000.

Source files
------------

// File: rtl/acc_multicanal_if.sv
// acc_multicanal_if: operand/control/read bundle for the multi-channel accumulator.
// The master drives operations and read selects. The slave returns the read data
// and the sticky overflow flags.
interface acc_multicanal_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [WIDTH-1:0]  Entrada;
    logic [CH_W-1:0]   Canal;
    logic [1:0]        Op;
    logic              WrAcc;
    logic              Clear;
    logic              ClearAll;
    logic [CH_W-1:0]   RdCanal;
    logic [WIDTH-1:0]  Salida;
    logic [NUM_CH-1:0] Overflow;

    modport master (
        output Entrada, Canal, Op, WrAcc, Clear, ClearAll, RdCanal,
        input  Salida, Overflow
    );

    modport slave (
        input  Entrada, Canal, Op, WrAcc, Clear, ClearAll, RdCanal,
        output Salida, Overflow
    );
endinterface

// File: rtl/acc_multicanal.sv
// acc_multicanal: NUM_CH independent signed WIDTH-bit accumulators.
// Supports ADD/SUB/LOAD, per-channel and global clear, and sticky overflow flags.
// The registered read port has write-through.
// Optional build macro ACC_MULTICANAL_SAT_EN: overflowing ADD/SUB results saturate
// instead of wrapping. The overflow flag is set in both builds.
module acc_multicanal #(
    parameter int WIDTH  = 16,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input logic             clk,
    input logic             rst_n,
    acc_multicanal_if.slave bus
);
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

`ifdef ACC_MULTICANAL_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [WIDTH-1:0]  acc_q [NUM_CH];
    logic [WIDTH-1:0]  acc_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0]  salida_q, salida_d;

    op_e              op;
    logic             tgt_in_range;
    logic             tgt_write;
    logic             tgt_ovf;
    logic [WIDTH-1:0] tgt_base;
    logic [WIDTH-1:0] tgt_res;

    assign op = op_e'(bus.Op);

    // Compute the operation result and overflow for the targeted channel. A clear on the same edge gives a zero base.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
        tgt_in_range = 1'b0;
        tgt_base     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.Canal == CH_W'(i)) begin
                tgt_in_range = 1'b1;
                tgt_base     = acc_q[i];
            end
        end
        if (bus.ClearAll || bus.Clear) tgt_base = '0;

        tgt_write = tgt_in_range && bus.WrAcc && (op != OP_NOP);
        tgt_res   = tgt_base;
        tgt_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                tgt_res = tgt_base + bus.Entrada;
                tgt_ovf = (tgt_base[WIDTH-1] == bus.Entrada[WIDTH-1]) &&
                          (tgt_res[WIDTH-1] != tgt_base[WIDTH-1]);
            end
            OP_SUB: begin
                tgt_res = tgt_base - bus.Entrada;
                tgt_ovf = (tgt_base[WIDTH-1] != bus.Entrada[WIDTH-1]) &&
                          (tgt_res[WIDTH-1] != tgt_base[WIDTH-1]);
            end
            OP_LOAD: tgt_res = bus.Entrada;
            default: tgt_res = tgt_base;
        endcase
`ifdef ACC_MULTICANAL_SAT_EN
        // An overflow always moves away from the base sign, so the base sign picks the rail.
        if (tgt_ovf) tgt_res = tgt_base[WIDTH-1] ? SAT_NEG : SAT_POS;
`endif
    end

    // Next state for every channel and flag, plus the write-through read value.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ClearAll || (bus.Clear && bus.Canal == CH_W'(i))) begin
                acc_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else begin
                acc_d[i] = acc_q[i];
                ovf_d[i] = ovf_q[i];
            end
            if (tgt_write && bus.Canal == CH_W'(i)) begin
                acc_d[i] = tgt_res;
                ovf_d[i] = ovf_d[i] | tgt_ovf;
            end
        end
        salida_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.RdCanal == CH_W'(i)) salida_d = acc_d[i];
        end
    end

    // State and output registers. The synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples the pre-edge values.
        if (!rst_n) begin
            acc_q    <= '{default: '0};
            ovf_q    <= '0;
            salida_q <= '0;
        end else begin
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            salida_q <= salida_d;
        end
    end

    assign bus.Salida   = salida_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_acc_multicanal.sv
// tb_acc_multicanal: directed and randomized checks of acc_multicanal.
// Two instances share one stimulus: NUM_CH=4 and NUM_CH=3 (out-of-range channel).
// The reference model works in plain integer arithmetic with range checks.
module tb_acc_multicanal;
    localparam int W    = 16;
    localparam int MAXP = 32767;
    localparam int MINN = -32768;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [W-1:0] entrada;
    logic [1:0]   canal, op, rd;
    logic         wr, clr, clra;

    acc_multicanal_if #(.WIDTH(W), .NUM_CH(4), .CH_W(2)) bus4 ();
    acc_multicanal_if #(.WIDTH(W), .NUM_CH(3), .CH_W(2)) bus3 ();

    assign bus4.Entrada  = entrada;
    assign bus4.Canal    = canal;
    assign bus4.Op       = op;
    assign bus4.WrAcc    = wr;
    assign bus4.Clear    = clr;
    assign bus4.ClearAll = clra;
    assign bus4.RdCanal  = rd;
    assign bus3.Entrada  = entrada;
    assign bus3.Canal    = canal;
    assign bus3.Op       = op;
    assign bus3.WrAcc    = wr;
    assign bus3.Clear    = clr;
    assign bus3.ClearAll = clra;
    assign bus3.RdCanal  = rd;

    acc_multicanal #(.WIDTH(W), .NUM_CH(4), .CH_W(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    acc_multicanal #(.WIDTH(W), .NUM_CH(3), .CH_W(2)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int checks = 0;
    int errors = 0;

    // Reference model state: index 0 = 4-channel instance, index 1 = 3-channel instance.
    logic [W-1:0] m_acc [2][4];
    bit           m_ovf [2][4];
    logic [W-1:0] m_sal [2];

`ifdef ACC_MULTICANAL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ovf_vec(input int k);
        logic [3:0] v = '0;
        for (int c = 0; c < 4; c++) v[c] = m_ovf[k][c];
        return v;
    endfunction

    task automatic model_step(input int k);
        int nch = (k == 0) ? 4 : 3;
        int b, e, r;
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                m_acc[k][c] = '0;
                m_ovf[k][c] = 1'b0;
            end
            m_sal[k] = '0;
        end else begin
            for (int c = 0; c < nch; c++) begin
                if (clra || (clr && int'(canal) == c)) begin
                    m_acc[k][c] = '0;
                    m_ovf[k][c] = 1'b0;
                end
            end
            if (wr && op != 2'd3 && int'(canal) < nch) begin
                b = int'($signed(m_acc[k][canal]));
                e = int'($signed(entrada));
                if (op == 2'd0) r = b + e;
                else if (op == 2'd1) r = b - e;
                else r = e;
                if (op != 2'd2 && (r > MAXP || r < MINN)) begin
                    m_ovf[k][canal] = 1'b1;
                    if (SAT) r = (r > MAXP) ? MAXP : MINN;
                end
                m_acc[k][canal] = r[W-1:0];
            end
            m_sal[k] = (int'(rd) < nch) ? m_acc[k][rd] : '0;
        end
    endtask

    // Apply one edge of stimulus, advance the model, then compare both instances away from the edge.
    task automatic step(input logic rn, input logic [1:0] ch, input logic [1:0] o, input logic [W-1:0] d,
                        input logic w, input logic c, input logic ca, input logic [1:0] r);
        rst_n = rn; canal = ch; op = o; entrada = d; wr = w; clr = c; clra = ca; rd = r;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("salida4", 32'(bus4.Salida), 32'(m_sal[0]));
        check("ovf4", 32'(bus4.Overflow), 32'(ovf_vec(0)));
        check("salida3", 32'(bus3.Salida), 32'(m_sal[1]));
        check("ovf3", 32'(bus3.Overflow), 32'({1'b0, ovf_vec(1)[2:0]}));
    endtask

    task automatic read_ch(input logic [1:0] ch);
        step(1'b1, 2'd0, 2'd3, 16'h0000, 1'b0, 1'b0, 1'b0, ch);
    endtask

    initial begin
        // 1. Reset with a pending ADD.
        step(1'b0, 2'd0, 2'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 2'd0);
        check("rst_salida", 32'(bus4.Salida), 32'h0);
        check("rst_ovf", 32'(bus4.Overflow), 32'h0);
        for (int c = 0; c < 4; c++) begin
            read_ch(2'(c));
            check("rst_read", 32'(bus4.Salida), 32'h0);
        end

        // 2. Accumulate on channel 1 with write-through.
        step(1'b1, 2'd1, 2'd0, 16'h0005, 1'b1, 1'b0, 1'b0, 2'd1);
        check("acc_1", 32'(bus4.Salida), 32'h0005);
        step(1'b1, 2'd1, 2'd0, 16'h0005, 1'b1, 1'b0, 1'b0, 2'd1);
        check("acc_2", 32'(bus4.Salida), 32'h000A);
        step(1'b1, 2'd1, 2'd0, 16'h0005, 1'b1, 1'b0, 1'b0, 2'd1);
        check("acc_3", 32'(bus4.Salida), 32'h000F);
        read_ch(2'd0); check("acc_ch0", 32'(bus4.Salida), 32'h0);
        read_ch(2'd2); check("acc_ch2", 32'(bus4.Salida), 32'h0);
        read_ch(2'd3); check("acc_ch3", 32'(bus4.Salida), 32'h0);

        // 3. Positive overflow on channel 2; a later LOAD keeps the flag.
        step(1'b1, 2'd2, 2'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 2'd2);
        step(1'b1, 2'd2, 2'd0, 16'h0001, 1'b1, 1'b0, 1'b0, 2'd2);
        check("povf_val", 32'(bus4.Salida), SAT ? 32'h7FFF : 32'h8000);
        check("povf_flag", 32'(bus4.Overflow[2]), 32'h1);
        step(1'b1, 2'd2, 2'd2, 16'h0010, 1'b1, 1'b0, 1'b0, 2'd2);
        check("load_val", 32'(bus4.Salida), 32'h0010);
        check("load_keeps_flag", 32'(bus4.Overflow[2]), 32'h1);

        // 4. Clear and ADD on channel 1 in the same edge.
        step(1'b1, 2'd1, 2'd0, 16'h0003, 1'b1, 1'b1, 1'b0, 2'd1);
        check("clr_wr_val", 32'(bus4.Salida), 32'h0003);
        check("clr_wr_flag", 32'(bus4.Overflow[1]), 32'h0);

        // 5. SUB of the most negative value from 0, then ClearAll with an ADD.
        step(1'b1, 2'd3, 2'd1, 16'h8000, 1'b1, 1'b0, 1'b0, 2'd3);
        check("nsub_val", 32'(bus4.Salida), SAT ? 32'h7FFF : 32'h8000);
        check("nsub_flag", 32'(bus4.Overflow[3]), 32'h1);
        step(1'b1, 2'd0, 2'd0, 16'h0002, 1'b1, 1'b0, 1'b1, 2'd0);
        check("clrall_val", 32'(bus4.Salida), 32'h0002);
        check("clrall_ovf", 32'(bus4.Overflow), 32'h0);
        for (int c = 1; c < 4; c++) begin
            read_ch(2'(c));
            check("clrall_read", 32'(bus4.Salida), 32'h0);
        end

        // 6. Out-of-range channel on the 3-channel instance: Clear and ADD to channel 3 do nothing.
        step(1'b1, 2'd2, 2'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 2'd2);
        step(1'b1, 2'd2, 2'd0, 16'h0001, 1'b1, 1'b0, 1'b0, 2'd2);
        step(1'b1, 2'd3, 2'd0, 16'h0001, 1'b1, 1'b1, 1'b0, 2'd3);
        check("oor_read", 32'(bus3.Salida), 32'h0);
        check("oor_ovf", 32'(bus3.Overflow), 32'h4);
        read_ch(2'd2); check("oor_ch2", 32'(bus3.Salida), SAT ? 32'h7FFF : 32'h8000);
        read_ch(2'd0); check("oor_ch0", 32'(bus3.Salida), 32'h0002);

        // Randomized traffic. Operands are biased toward extremes to provoke overflow.
        for (int n = 0; n < 600; n++) begin
            logic [W-1:0] d;
            case ($urandom_range(0, 3))
                0: d = 16'h7FFF - W'($urandom_range(0, 3));
                1: d = 16'h8000 + W'($urandom_range(0, 3));
                default: d = W'($urandom);
            endcase
            step(($urandom_range(0, 49) != 0), 2'($urandom), 2'($urandom), d,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 31) == 0), 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
